// File: rtl/counter_timer_bank.sv
// Multi-channel counter/timer bank behind a simple CPU register bus.
// Each channel counts clk or synchronised src edges, optionally gated, and flags terminal count.
module counter_timer_bank #(
  parameter int NCHAN = 5,
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs,
  input  logic             wr,
  input  logic             rd,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [NCHAN-1:0] src,
  input  logic [NCHAN-1:0] gate,
  output logic [NCHAN-1:0] out,
  output logic             irq
);

  localparam int CW = AW - 2;

  logic [CW-1:0]    sel_ch;
  logic [1:0]       sel_reg;

  logic [5:0]       mode_q [NCHAN];
  logic [WIDTH-1:0] load_q [NCHAN];
  logic [WIDTH-1:0] hold_q [NCHAN];
  logic [WIDTH-1:0] cnt_q  [NCHAN];
  logic [NCHAN-1:0] armed_q, tc_q, out_q;
  logic             irq_q;

  logic [NCHAN-1:0] src_s1, src_s2, src_s3, gate_s1, gate_s2;
  logic [NCHAN-1:0] src_edge;

  logic [4:0]       ctl    [NCHAN];
  logic [NCHAN-1:0] mode_wr, load_wr, tick, tc_ev, irq_en;
  logic [WIDTH-1:0] rd_val;

  assign sel_ch   = addr[AW-1:2];
  assign sel_reg  = addr[1:0];
  assign src_edge = src_s2 & ~src_s3;
  assign out      = out_q;
  assign irq      = irq_q;

  // Per-channel decode and tick qualification; loads and disarms override the tick.
  always_comb begin
    mode_wr = '0;
    load_wr = '0;
    tick    = '0;
    tc_ev   = '0;
    irq_en  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      ctl[c]     = 5'b0;
      mode_wr[c] = cs && wr && (sel_ch == CW'(c)) && (sel_reg == 2'd0);
      load_wr[c] = cs && wr && (sel_ch == CW'(c)) && (sel_reg == 2'd1);
      if (cs && wr && (sel_ch == CW'(c)) && (sel_reg == 2'd3))
        ctl[c] = wdata[4:0];
      tick[c]   = (mode_q[c][0] ? src_edge[c] : 1'b1) && armed_q[c] &&
                  (!mode_q[c][1] || gate_s2[c]) && !ctl[c][1];
      tc_ev[c]  = tick[c] && !ctl[c][2] &&
                  (mode_q[c][4] ? (cnt_q[c] == load_q[c]) : (cnt_q[c] == '0));
      irq_en[c] = mode_q[c][5];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (sel_ch == CW'(c)) begin
        case (sel_reg)
          2'd0:    rd_val = {{(WIDTH-6){1'b0}}, mode_q[c]};
          2'd1:    rd_val = load_q[c];
          2'd2:    rd_val = hold_q[c];
          default: rd_val = {{(WIDTH-3){1'b0}}, out_q[c], tc_q[c], armed_q[c]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_s1  <= '0;
      src_s2  <= '0;
      src_s3  <= '0;
      gate_s1 <= '0;
      gate_s2 <= '0;
      armed_q <= '0;
      tc_q    <= '0;
      out_q   <= '0;
      irq_q   <= 1'b0;
      rdata   <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        mode_q[c] <= '0;
        load_q[c] <= '0;
        hold_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      src_s1  <= src;
      src_s2  <= src_s1;
      src_s3  <= src_s2;
      gate_s1 <= gate;
      gate_s2 <= gate_s1;
      irq_q   <= |(tc_q & irq_en);
      if (cs && rd)
        rdata <= rd_val;
      for (int c = 0; c < NCHAN; c++) begin
        if (mode_wr[c])
          mode_q[c] <= wdata[5:0];
        if (load_wr[c])
          load_q[c] <= wdata;
        if (ctl[c][3])
          hold_q[c] <= cnt_q[c];

        if (ctl[c][2])
          cnt_q[c] <= load_q[c];
        else if (tick[c]) begin
          if (tc_ev[c])
            cnt_q[c] <= mode_q[c][4] ? '0 : load_q[c];
          else
            cnt_q[c] <= mode_q[c][4] ? cnt_q[c] + WIDTH'(1) : cnt_q[c] - WIDTH'(1);
        end

        armed_q[c] <= (armed_q[c] || ctl[c][0]) && !ctl[c][1] &&
                      !(tc_ev[c] && !mode_q[c][2]);
        tc_q[c]    <= tc_ev[c] || (tc_q[c] && !ctl[c][4]);
        out_q[c]   <= mode_q[c][3] ? (out_q[c] ^ tc_ev[c]) : tc_ev[c];
      end
    end
  end

endmodule

// File: tb/tb_counter_timer_bank.sv
// Directed bench for counter_timer_bank: a cycle model checks out/irq/rdata every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_counter_timer_bank;

  localparam int NCHAN = 5;
  localparam int WIDTH = 16;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic [NCHAN-1:0] src = '0, gate = '0;
  logic [NCHAN-1:0] out;
  logic             irq;

  counter_timer_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata), .src(src), .gate(gate), .out(out), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: channel state as plain numbers, src/gate synchronisers as sample histories.
  logic [5:0]       m_mode [NCHAN];
  logic [WIDTH-1:0] m_load [NCHAN];
  logic [WIDTH-1:0] m_hold [NCHAN];
  logic [WIDTH-1:0] m_cnt  [NCHAN];
  bit               m_armed [NCHAN];
  bit               m_tc    [NCHAN];
  bit               m_out   [NCHAN];
  bit               m_irq;
  logic [WIDTH-1:0] m_rdata;
  logic [NCHAN-1:0] sh [1:3];
  logic [NCHAN-1:0] gh [1:3];

  function automatic logic [WIDTH-1:0] m_read(int ch, int r);
    if (ch >= NCHAN) return '0;
    case (r)
      0: return WIDTH'(m_mode[ch]);
      1: return m_load[ch];
      2: return m_hold[ch];
      default: return WIDTH'({m_out[ch], m_tc[ch], m_armed[ch]});
    endcase
  endfunction

  task automatic model_step();
    int ch, r;
    bit any, tick, tcev, up;
    logic [4:0] ctl;
    if (!reset_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        m_mode[c] = '0; m_load[c] = '0; m_hold[c] = '0; m_cnt[c] = '0;
        m_armed[c] = 0; m_tc[c] = 0; m_out[c] = 0;
      end
      m_irq = 0;
      m_rdata = '0;
      for (int k = 1; k <= 3; k++) begin sh[k] = '0; gh[k] = '0; end
      return;
    end
    ch = int'(addr) / 4;
    r  = int'(addr) % 4;
    if (cs && rd) m_rdata = m_read(ch, r);
    any = 0;
    for (int c = 0; c < NCHAN; c++) if (m_tc[c] && m_mode[c][5]) any = 1;
    for (int c = 0; c < NCHAN; c++) begin
      ctl  = (cs && wr && ch == c && r == 3) ? wdata[4:0] : 5'b0;
      up   = m_mode[c][4];
      tick = (m_mode[c][0] ? (sh[2][c] && !sh[3][c]) : 1'b1) && m_armed[c] &&
             (!m_mode[c][1] || gh[2][c]) && !ctl[1];
      tcev = 0;
      if (ctl[3]) m_hold[c] = m_cnt[c];
      if (ctl[2]) m_cnt[c] = m_load[c];
      else if (tick) begin
        if (up && m_cnt[c] == m_load[c])   begin tcev = 1; m_cnt[c] = 0; end
        else if (!up && m_cnt[c] == 0)     begin tcev = 1; m_cnt[c] = m_load[c]; end
        else if (up) m_cnt[c] = m_cnt[c] + 1;
        else         m_cnt[c] = m_cnt[c] - 1;
      end
      m_out[c] = m_mode[c][3] ? (m_out[c] ^ tcev) : tcev;
      if (ctl[0]) m_armed[c] = 1;
      if (ctl[1]) m_armed[c] = 0;
      if (tcev && !m_mode[c][2]) m_armed[c] = 0;
      if (ctl[4]) m_tc[c] = 0;
      if (tcev)   m_tc[c] = 1;
      if (cs && wr && ch == c && r == 0) m_mode[c] = wdata[5:0];
      if (cs && wr && ch == c && r == 1) m_load[c] = wdata;
    end
    m_irq = any;
    sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = src;
    gh[3] = gh[2]; gh[2] = gh[1]; gh[1] = gate;
  endtask

  always @(posedge clk) model_step();

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int c = 0; c < NCHAN; c++) check($sformatf("model_out%0d", c), out[c], m_out[c]);
      check("model_irq", irq, m_irq);
      check("model_rdata", rdata, m_rdata);
    end
  end

  task automatic wr_reg(int ch, int r, logic [WIDTH-1:0] d);
    cs = 1; wr = 1; addr = AW'(ch * 4 + r); wdata = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic rd_reg(int ch, int r, output logic [WIDTH-1:0] v);
    cs = 1; rd = 1; addr = AW'(ch * 4 + r);
    @(negedge clk);
    v = rdata;
    cs = 0; rd = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk_en  = 1;
    check("rst_out", out, 0);
    check("rst_irq", irq, 0);

    // One-shot down count on ch0 with irq
    wr_reg(0, 0, 16'h20);
    wr_reg(0, 1, 16'd3);
    wr_reg(0, 3, 16'h05);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("os_out_k%0d", k), out[0], k == 4);
      check($sformatf("os_irq_k%0d", k), irq, k >= 5);
    end
    rd_reg(0, 3, v);  check("os_status", v, 16'h2);
    wr_reg(0, 3, 16'h10);
    check("os_irq_clr_edge", irq, 1);
    @(negedge clk);
    check("os_irq_fall", irq, 0);
    wr_reg(0, 3, 16'h05);
    wr_reg(0, 3, 16'h08);
    rd_reg(0, 2, v);  check("os_hold_first", v, 16'd3);
    repeat (6) @(negedge clk);
    wr_reg(0, 3, 16'h10);

    // Repeat toggle on src for ch2
    wr_reg(2, 0, 16'h0D);
    wr_reg(2, 1, 16'd1);
    wr_reg(2, 3, 16'h05);
    for (int e = 1; e <= 6; e++) begin
      src[2] = 1;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("tg_before_e%0d", e), out[2], ((e - 1) / 2) % 2);
      @(negedge clk);
      check($sformatf("tg_after_e%0d", e), out[2], (e / 2) % 2);
      src[2] = 0;
      repeat (3) @(negedge clk);
    end
    rd_reg(2, 3, v);  check("tg_status", v, 16'h7);

    // Gated up count on ch1
    wr_reg(1, 0, 16'h12);
    wr_reg(1, 1, 16'd0);
    wr_reg(1, 3, 16'h04);
    wr_reg(1, 1, 16'd5);
    wr_reg(1, 3, 16'h01);
    repeat (10) @(negedge clk);
    wr_reg(1, 3, 16'h08);
    rd_reg(1, 2, v);  check("gate_low_hold", v, 16'd0);
    gate[1] = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("up_out_k%0d", k), out[1], k == 8);
    end
    wr_reg(1, 3, 16'h08);
    rd_reg(1, 2, v);  check("up_hold_wrap", v, 16'd0);
    rd_reg(1, 3, v);  check("up_status", v, 16'h2);
    gate[1] = 0;

    // Save and disarm collisions on ch3
    wr_reg(3, 0, 16'h04);
    wr_reg(3, 1, 16'd100);
    wr_reg(3, 3, 16'h05);
    repeat (4) @(negedge clk);
    wr_reg(3, 3, 16'h08);
    rd_reg(3, 2, v);  check("save_pre_edge", v, 16'd96);
    wr_reg(3, 3, 16'h02);
    wr_reg(3, 3, 16'h08);
    rd_reg(3, 2, v);  check("disarm_beats_tick", v, 16'd94);

    // Clear on the TC edge of ch4
    wr_reg(4, 0, 16'h04);
    wr_reg(4, 1, 16'd2);
    wr_reg(4, 3, 16'h05);
    repeat (2) @(negedge clk);
    wr_reg(4, 3, 16'h10);
    rd_reg(4, 3, v);  check("tc_beats_clear", v, 16'h7);
    wr_reg(4, 3, 16'h02);

    // Decode boundary: channel 6 does not exist
    wr_reg(6, 0, 16'hFFFF);
    wr_reg(6, 1, 16'h1234);
    wr_reg(6, 3, 16'h001F);
    for (int r = 0; r < 4; r++) begin
      rd_reg(6, r, v);  check($sformatf("ch6_r%0d", r), v, 16'h0);
    end
    rd_reg(0, 0, v);  check("ch0_mode_kept", v, 16'h20);
    rd_reg(0, 1, v);  check("ch0_load_kept", v, 16'd3);
    rd_reg(2, 0, v);  check("ch2_mode_kept", v, 16'h0D);
    rd_reg(2, 3, v);  check("ch2_status_kept", v, 16'h7);

    // Reset mid-count on every channel
    for (int c = 0; c < NCHAN; c++) begin
      wr_reg(c, 0, 16'h2C);
      wr_reg(c, 1, WIDTH'(3 + c));
      wr_reg(c, 3, 16'h05);
    end
    repeat (7) @(negedge clk);
    reset_n = 0;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int c = 0; c < NCHAN; c++)
      for (int r = 0; r < 4; r++) begin
        rd_reg(c, r, v);  check($sformatf("post_rst_c%0d_r%0d", c, r), v, 16'h0);
      end
    repeat (5) @(negedge clk);
    wr_reg(0, 3, 16'h08);
    rd_reg(0, 2, v);  check("post_rst_cnt_idle", v, 16'h0);
    check("post_rst_out", out, 0);
    check("post_rst_irq", irq, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_timer_bank.md
Name: counter_timer_bank

Overview:
- Synthesizable, parametrised multi-channel counter/timer, the successor to the Am9513 timer stub in the board model.
- Provides NCHAN independent counters, each with:
  - a selectable count source (system clock or external source pin), with optional gating
  - a load register, a hold/save register, one-shot or repeat mode, up or down counting
  - a pulse or toggle output and a maskable interrupt
- Sits behind the CPU-side register bus; drives the OUTn pins and the timer interrupt request.

Parameters:
- NCHAN, 5, number of counter channels (1..8).
- WIDTH, 16, counter and data-bus width.
- AW, 5, address width; must be >= clog2(NCHAN)+2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select, synchronous to clk.
- wr  in  1  write strobe; a write occurs on every clk edge with cs&wr.
- rd  in  1  read strobe; a read occurs on every clk edge with cs&rd.
- addr  in  AW  register address: channel = addr[AW-1:2], register = addr[1:0].
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data.
- src  in  NCHAN  external count sources, asynchronous.
- gate  in  NCHAN  external gates, asynchronous.
- out  out  NCHAN  channel outputs.
- irq  out  1  interrupt request, active high.

Behaviour:
- Register map, per channel:
  - r0 MODE (R/W):
    - b0 source: 0 = clk, 1 = src rising edge.
    - b1 gate enable.
    - b2 repeat.
    - b3 out mode: 0 = pulse, 1 = toggle.
    - b4 direction: 0 = down, 1 = up.
    - b5 irq enable.
    - Other bits read 0.
  - r1 LOAD (R/W).
  - r2 HOLD (read-only; writes ignored).
  - r3 CONTROL:
    - Write, actions taken when the bit is 1: b0 arm, b1 disarm, b2 load counter <= LOAD, b3 save HOLD <= counter, b4 clear tc flag.
    - Read: b0 armed, b1 tc flag, b2 out.
  - Addresses for channels >= NCHAN read 0; writes to them are ignored.
- Reset: all MODE/LOAD/HOLD/counters = 0, disarmed, tc flags 0, out = 0, irq = 0, rdata = 0.
- Read path:
  - rdata is loaded on the edge where cs&rd, valid the following cycle, and held otherwise.
  - HOLD and status read values are taken from before that edge's updates.
- Input synchronisation:
  - src and gate pass through 2-flop synchronisers.
  - src edge = sync1 & ~sync2_prev. A src rising edge produces a tick 3 clk cycles after the pin change.
- Tick, per channel:
  - Source event (every clk if b0 = 0, else synchronised src edge).
  - AND armed.
  - AND (b1 = 0 OR synchronised gate = 1).
- Down count, on tick:
  - If counter == 0: terminal count (TC). Counter <= LOAD.
  - Else counter <= counter-1.
- Up count, on tick:
  - If counter == LOAD: TC. Counter <= 0.
  - Else counter <= counter+1; wraps 2^WIDTH-1 -> 0 without TC.
- On TC:
  - tc flag <= 1.
  - If repeat = 0, the channel disarms in the same edge.
- Output:
  - Pulse mode: out = 1 for exactly the one cycle following the TC edge, else 0.
  - Toggle mode: out inverts on each TC.
  - Changing b3 does not alter the current out level.
- irq = OR over channels of (tc flag & b5), registered, asserted the cycle after the flag sets.
- Simultaneous events, same edge:
  - Control load beats tick: counter = LOAD, no TC.
  - Disarm beats tick: no count.
  - Arm plus load: counter loaded; counting starts the next edge.
  - Save captures the pre-update counter value.
  - TC reload uses the pre-write LOAD value.
  - A new TC beats a clear: the flag stays 1.
  - A LOAD write does not affect the counter until a load command or a TC reload.
- reset_n low at any time immediately forces the reset state, including mid-count and mid-pulse.

Test Plan:
- Reset values: assert reset_n = 0 mid-count on all channels -> every register reads 0, out = 0, irq = 0; after release, channel counters stay 0 while disarmed.
- One-shot down count:
  - Setup: ch0 MODE = 0x20 (clk source, irq enable), LOAD = 3, CONTROL = 0x05 (load + arm).
  - Counter sequence 3, 2, 1, 0; on the next tick counter = 3 and TC fires.
  - out0 pulses high for 1 cycle, the channel disarms, and irq rises the following cycle.
  - CONTROL write 0x10 -> irq falls.
- Repeat toggle on external source:
  - Setup: ch2 MODE = 0x0D (src, repeat, toggle), LOAD = 1, arm.
  - Drive 6 src rising edges -> out2 toggles after edges 2, 4 and 6; each toggle comes 3 clk after its src edge.
  - The channel stays armed.
- Gating and up count:
  - Setup: ch1 MODE = 0x12 (clk source, gate enable, up count), LOAD = 5, counter cleared, arm.
  - Gate low for 10 cycles -> counter stays 0.
  - Gate high -> TC after 6 ticks, counter returns to 0.
- Save/read and collisions:
  - Save (CONTROL = 0x08) while counting -> HOLD equals the pre-edge counter value.
  - Disarm issued on the same edge as a tick -> no decrement.
  - Clear issued on the same edge as a TC -> tc flag reads 1.
- Decode boundary: with NCHAN = 5, write then read channel 6 -> rdata = 0 and no channel state changes.
